// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port MIPS register file:
// register index constants, default sizes and the clear/ready state type.
package regfile_mp_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_NREGS  = 32;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_V0   = 2;
    localparam int unsigned REG_A0   = 4;
    localparam int unsigned REG_T0   = 8;
    localparam int unsigned REG_T1   = 9;
    localparam int unsigned REG_RA   = 31;

    typedef enum logic {StClear, StReady} rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between the core pipeline (master) and the register file (slave):
// read ports, two writeback ports, issue marking and the debug tap.
interface regfile_mp_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned RD_PORTS = 2
);
    logic                       ready;
    logic [RD_PORTS*AW-1:0]     rd_addr;
    logic [RD_PORTS*DATA_W-1:0] rd_data;
    logic [RD_PORTS-1:0]        rd_pend;
    logic                       wr0_en;
    logic [AW-1:0]              wr0_addr;
    logic [DATA_W-1:0]          wr0_data;
    logic                       wr1_en;
    logic [AW-1:0]              wr1_addr;
    logic [DATA_W-1:0]          wr1_data;
    logic                       iss_en;
    logic [AW-1:0]              iss_addr;
    logic [AW-1:0]              dbg_addr;
    logic [DATA_W-1:0]          dbg_data;

    modport master (
        input  ready, rd_data, rd_pend, dbg_data,
        output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               iss_en, iss_addr, dbg_addr
    );

    modport slave (
        output ready, rd_data, rd_pend, dbg_data,
        input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               iss_en, iss_addr, dbg_addr
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register marking an in-flight producer,
// plus a combinational lookup for each read port.
module regfile_scoreboard #(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    input  logic                   wr0_en,
    input  logic [AW-1:0]          wr0_addr,
    input  logic                   wr1_en,
    input  logic [AW-1:0]          wr1_addr,
    input  logic [RD_PORTS*AW-1:0] rd_addr,
    output logic [RD_PORTS-1:0]    rd_pend
);
    logic [NREGS-1:0] pending_q, pending_d;

    // Issue is applied after the clears so a new producer supersedes a retiring one.
    always_comb begin
        pending_d = pending_q;
        if (wr0_en) pending_d[wr0_addr] = 1'b0;
        if (wr1_en) pending_d[wr1_addr] = 1'b0;
        if (iss_en) pending_d[iss_addr] = 1'b1;
        if (ZERO_REG != 0) pending_d[0] = 1'b0;
        if (clear) pending_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    always_comb begin
        rd_pend = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            rd_pend[p] = pending_q[rd_addr[p*AW +: AW]];
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: write-first registered reads, prioritised dual writeback,
// debug tap, and a post-reset sequencer that zeroes one entry per cycle.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NREGS    = DEF_NREGS,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);
    localparam int unsigned AW     = $clog2(NREGS);
    localparam bit          ZERO_EN = (ZERO_REG != 0);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [DATA_W-1:0]          mem [NREGS];
    rf_state_e                  state_q;
    logic [AW-1:0]              clr_idx_q;
    logic                       ready_q;
    logic [RD_PORTS*DATA_W-1:0] rd_data_q, rd_data_d;

    logic active, wr0_ok, wr1_ok, iss_ok;

    assign active = (state_q == StReady);
    assign wr0_ok = active && bus.wr0_en && !(ZERO_EN && bus.wr0_addr == ZERO_ADDR);
    assign wr1_ok = active && bus.wr1_en && !(ZERO_EN && bus.wr1_addr == ZERO_ADDR);
    assign iss_ok = active && bus.iss_en;

    // ready lags the state by one edge so it rises NREGS+1 edges after reset release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            ready_q <= (state_q == StReady);
            if (state_q == StClear) begin
                clr_idx_q <= clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NREGS - 1)) state_q <= StReady;
            end
        end
    end

    // wr1 is written last so it wins a same-address conflict.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == StClear) begin
                mem[clr_idx_q] <= '0;
            end else begin
                if (wr0_ok) mem[bus.wr0_addr] <= bus.wr0_data;
                if (wr1_ok) mem[bus.wr1_addr] <= bus.wr1_data;
            end
        end
    end

    function automatic logic [DATA_W-1:0] bypass_rd(input logic [AW-1:0] a);
        logic [DATA_W-1:0] v;
        v = mem[a];
        if (wr0_ok && bus.wr0_addr == a) v = bus.wr0_data;
        if (wr1_ok && bus.wr1_addr == a) v = bus.wr1_data;
        if (ZERO_EN && a == ZERO_ADDR) v = '0;
        return v;
    endfunction

    always_comb begin
        rd_data_d = '0;
        if (active) begin
            for (int p = 0; p < RD_PORTS; p++) begin
                rd_data_d[p*DATA_W +: DATA_W] = bypass_rd(bus.rd_addr[p*AW +: AW]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    assign bus.ready    = ready_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.dbg_data = (active && !(ZERO_EN && bus.dbg_addr == ZERO_ADDR)) ?
                          mem[bus.dbg_addr] : '0;

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .RD_PORTS (RD_PORTS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!active),
        .iss_en   (iss_ok),
        .iss_addr (bus.iss_addr),
        .wr0_en   (wr0_ok),
        .wr0_addr (bus.wr0_addr),
        .wr1_en   (wr1_ok),
        .wr1_addr (bus.wr1_addr),
        .rd_addr  (bus.rd_addr),
        .rd_pend  (bus.rd_pend)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a vector table for reads/writes/bypass/scoreboard,
// plus hand-written reset-clear and mid-clear-reset sequences.
module tb_regfile_mp;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    regfile_mp_if #(.DATA_W(32), .AW(5), .RD_PORTS(2)) bus ();

    regfile_mp #(
        .DATA_W   (32),
        .NREGS    (32),
        .RD_PORTS (2),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w0e;
        logic [4:0]  w0a;
        logic [31:0] w0d;
        logic        w1e;
        logic [4:0]  w1a;
        logic [31:0] w1d;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [4:0]  da;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_pend;
        logic [31:0] e_dbg;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wr0_en = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
        bus.wr1_en = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0;
    endtask

    // Counts edges after reset release until ready rises; 0 means it never did.
    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.ready === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    int n_rdy;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        bus.rd_addr  = '0;
        bus.dbg_addr = '0;

        vecs[0]  = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        0, 5'd0,
                     5'd5,  5'd0,  5'd5,  32'hDEADBEEF, 32'h0,        2'b00, 32'hDEADBEEF};
        vecs[1]  = '{1, 5'd8,  32'h12345678, 0, 5'd0,  32'h0,        0, 5'd0,
                     5'd8,  5'd5,  5'd8,  32'h12345678, 32'hDEADBEEF, 2'b00, 32'h12345678};
        vecs[2]  = '{1, 5'd9,  32'h1,        1, 5'd9,  32'h2,        0, 5'd0,
                     5'd9,  5'd8,  5'd9,  32'h2,        32'h12345678, 2'b00, 32'h2};
        vecs[3]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,
                     5'd9,  5'd9,  5'd9,  32'h2,        32'h2,        2'b00, 32'h2};
        vecs[4]  = '{0, 5'd0,  32'h0,        1, 5'd0,  32'hFFFFFFFF, 0, 5'd0,
                     5'd0,  5'd9,  5'd0,  32'h0,        32'h2,        2'b00, 32'h0};
        vecs[5]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd0,
                     5'd0,  5'd10, 5'd0,  32'h0,        32'h0,        2'b00, 32'h0};
        vecs[6]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd10,
                     5'd10, 5'd0,  5'd10, 32'h0,        32'h0,        2'b01, 32'h0};
        vecs[7]  = '{1, 5'd10, 32'hAAAA,     0, 5'd0,  32'h0,        1, 5'd10,
                     5'd10, 5'd0,  5'd10, 32'hAAAA,     32'h0,        2'b01, 32'hAAAA};
        vecs[8]  = '{0, 5'd0,  32'h0,        1, 5'd10, 32'hBBBB,     0, 5'd0,
                     5'd10, 5'd10, 5'd10, 32'hBBBB,     32'hBBBB,     2'b00, 32'hBBBB};
        vecs[9]  = '{1, 5'd4,  32'h44,       0, 5'd0,  32'h0,        1, 5'd3,
                     5'd3,  5'd4,  5'd4,  32'h0,        32'h44,       2'b01, 32'h44};
        vecs[10] = '{1, 5'd3,  32'h33,       1, 5'd4,  32'h55,       0, 5'd0,
                     5'd3,  5'd4,  5'd4,  32'h33,       32'h55,       2'b00, 32'h55};
        vecs[11] = '{0, 5'd0,  32'h0,        1, 5'd31, 32'h1F1F,     0, 5'd0,
                     5'd31, 5'd3,  5'd31, 32'h1F1F,     32'h33,       2'b00, 32'h1F1F};

        // Power-on reset
        step();
        step();
        chk("reset_ready", {31'b0, bus.ready}, 32'h0);
        chk("reset_rd_data", bus.rd_data[31:0] | bus.rd_data[63:32], 32'h0);
        chk("reset_rd_pend", {30'b0, bus.rd_pend}, 32'h0);
        rst_n = 1'b1;
        wait_ready(n_rdy);
        chk("initial_ready_latency", n_rdy, 33);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            bus.wr0_en = vecs[i].w0e; bus.wr0_addr = vecs[i].w0a; bus.wr0_data = vecs[i].w0d;
            bus.wr1_en = vecs[i].w1e; bus.wr1_addr = vecs[i].w1a; bus.wr1_data = vecs[i].w1d;
            bus.iss_en = vecs[i].ie;  bus.iss_addr = vecs[i].ia;
            bus.rd_addr  = {vecs[i].ra1, vecs[i].ra0};
            bus.dbg_addr = vecs[i].da;
            step();
            chk($sformatf("vec%0d_rd0", i), bus.rd_data[31:0], vecs[i].e_rd0);
            chk($sformatf("vec%0d_rd1", i), bus.rd_data[63:32], vecs[i].e_rd1);
            chk($sformatf("vec%0d_pend", i), {30'b0, bus.rd_pend}, {30'b0, vecs[i].e_pend});
            chk($sformatf("vec%0d_dbg", i), bus.dbg_data, vecs[i].e_dbg);
        end
        idle_inputs();

        // Reset clears array and scoreboard
        bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
        bus.rd_addr = {5'd5, 5'd7};
        step();
        idle_inputs();
        chk("pre_reset_pend_r7", {31'b0, bus.rd_pend[0]}, 32'h1);
        chk("pre_reset_r5", bus.rd_data[63:32], 32'hDEADBEEF);
        rst_n = 1'b0;
        step();
        chk("pulse_reset_ready", {31'b0, bus.ready}, 32'h0);
        chk("pulse_reset_rd_data", bus.rd_data[63:32], 32'h0);
        rst_n = 1'b1;
        wait_ready(n_rdy);
        chk("pulse_ready_latency", n_rdy, 33);
        bus.rd_addr = {5'd7, 5'd5};
        step();
        chk("post_clear_r5", bus.rd_data[31:0], 32'h0);
        chk("post_clear_pend_r7", {31'b0, bus.rd_pend[1]}, 32'h0);

        // Mid-clear reset, with writes and issues attempted during CLEAR
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd20; bus.wr0_data = 32'h2020;
        step();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd1; bus.wr0_data = 32'h1111;
        bus.wr1_en = 1'b1; bus.wr1_addr = 5'd2; bus.wr1_data = 32'h2222;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd14;
        bus.rd_addr = {5'd0, 5'd20};
        bus.dbg_addr = 5'd20;
        n_rdy = 0;
        for (int i = 1; i <= 40 && n_rdy == 0; i++) begin
            if (i == 21) idle_inputs();
            step();
            if (bus.ready === 1'b1) n_rdy = i;
            if (i <= 20) begin
                chk($sformatf("clear%0d_rd0_forced", i), bus.rd_data[31:0], 32'h0);
                chk($sformatf("clear%0d_dbg_forced", i), bus.dbg_data, 32'h0);
            end
        end
        idle_inputs();
        chk("midclear_ready_latency", n_rdy, 33);
        bus.rd_addr = {5'd2, 5'd1};
        step();
        chk("midclear_r1", bus.rd_data[31:0], 32'h0);
        chk("midclear_r2", bus.rd_data[63:32], 32'h0);
        chk("midclear_dbg_r20", bus.dbg_data, 32'h0);
        bus.rd_addr = {5'd20, 5'd14};
        step();
        chk("midclear_pend_r14", {31'b0, bus.rd_pend[0]}, 32'h0);
        chk("midclear_r20", bus.rd_data[63:32], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
